conv_line_packer_1d: RTL and testbench
======================================

// Module: conv_line_packer_1d
// PURPOSE
//   Upstream feeder for the 1-D full-parallel convolution stage. Accepts a pixel stream
//   (one beat = all IMG_D channels of one column) over valid/ready and assembles IMG_W beats
//   into the flat lines vector that the conv stage consumes. Ping-pong buffered, so input
//   runs at full rate while a completed line is held. Carries an 8-bit opaque tag per line.
// PARAMETERS
//   DATA_WIDTH  8   bits per element
//   IMG_W       32  columns per line (beats per line)
//   IMG_D       8   channels per column
//   COL_AW      $clog2(IMG_W), derived, do not set
// PORTS
//   clk         in   1                      clock, rising edge
//   reset       in   1                      async reset, ACTIVE-LOW (reset==0 resets)
//   in_data     in   DATA_WIDTH*IMG_D       channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_valid    in   1                      beat valid
//   in_ready    out  1                      beat accepted when in_valid&in_ready
//   opaque_in   in   8                      line tag, sampled on first beat (col 0)
//   lines_out   out  DATA_WIDTH*IMG_D*IMG_W (k,w) at [(k*IMG_W+w)*DATA_WIDTH +: DATA_WIDTH]
//   out_valid   out  1                      lines_out/opaque_out hold a complete line
//   out_ready   in   1                      line consumed when out_valid&out_ready
//   opaque_out  out  8                      tag of the line on lines_out
//   in_last     in   1   [CONV_PACK_LAST_CHECK_EN only] marks final beat of line
//   err_out     out  1   [CONV_PACK_LAST_CHECK_EN only] sticky framing error
// BEHAVIOUR
//   - One clock domain. Reset (async assert, sync release): wr_col=0, wr_bank=0, rd_bank=0,
//     full[1:0]=0; in_ready=1 after reset, out_valid=0, lines_out=0, opaque_out=0, err_out=0.
//   - Per-bank states: EMPTY -> FILLING (first beat accepted) -> FULL (beat IMG_W-1 accepted)
//     -> EMPTY (output handshake). Bank regs: data, 8-bit tag.
//   - in_ready = !full[wr_bank] (registered-state only, no combinational path from out_ready).
//   - Input fire: write in_data to column wr_col of bank wr_bank; if wr_col==0 also store
//     opaque_in. If wr_col==IMG_W-1: wr_col<=0, full[wr_bank]<=1, wr_bank<=~wr_bank;
//     else wr_col<=wr_col+1. No fire: no state change.
//   - out_valid = full[rd_bank]; lines_out/opaque_out = bank[rd_bank] (mux of registers).
//     Output fire: full[rd_bank]<=0, rd_bank<=~rd_bank. Data stable while out_valid&!out_ready.
//   - Latency: last beat accepted in cycle N -> out_valid=1 in cycle N+1.
//   - Throughput: 1 beat/cycle sustained if out_ready drains each line within IMG_W cycles.
//   - Both banks FULL: in_ready=0 until an output fire; the freed bank accepts next cycle.
//   - Same-cycle last-beat input fire and output fire act on different banks; both apply.
//   - Same bank never simultaneously filled and drained (FULL bank never written).
//   - Reset mid-line: partial line discarded; output in progress dropped.
// CONFIGURATION
//   CONV_PACK_LAST_CHECK_EN defined: in_last/err_out ports exist.
//     - fire with in_last=1 and wr_col!=IMG_W-1: partial line discarded (wr_col<=0, bank
//       stays EMPTY, wr_bank unchanged), err_out<=1.
//     - fire at wr_col==IMG_W-1 with in_last=0: line committed normally, err_out<=1.
//     - err_out sticky, cleared only by reset.
//   Not defined: ports absent; lines framed purely by beat count.
// STRUCTURE
//   - conv_1d_pkg: localparam helpers elem_lsb(k,w,IMG_W,DATA_WIDTH), bank_state_e
//     {EMPTY,FILLING,FULL}, OPAQUE_W=8.
//   - Sub-module conv_line_bank: one bank (column write-enable decode, data + tag regs,
//     async active-low reset); instantiated twice; top holds counters, flags, output mux.
// TESTING  (DATA_WIDTH=8, IMG_W=4, IMG_D=2)
//   - Reset: hold reset=0 -> in_ready=1, out_valid=0, lines_out=0, opaque_out=0.
//   - Single line: beats {ch1,ch0}={01,00},{11,10},{21,20},{31,30}, opaque_in=0xA5 at beat 0,
//     out_ready=1 -> out_valid 1 cycle after beat 3, lines_out=64'h31211101_30201000, tag A5.
//   - Backpressure: out_ready=0, stream 3 lines -> 2 lines buffered, in_ready=0 on 9th beat;
//     release out_ready -> lines emerge in order, tags intact, no beat lost.
//   - Full rate: in_valid=1 continuously, out_ready=1 -> in_ready never drops, 1 line/4 cycles.
//   - Reset mid-line after 2 beats -> no out_valid; next 4 beats form a clean line.
//   - LAST_CHECK_EN: in_last=1 on beat 1 -> err_out=1, no line output; next 4 beats output.

Source files
------------

// File: rtl/conv_1d_pkg.sv
// Shared types and helpers for the 1-D conv line packer.
// Optional build macro used by the packer: CONV_PACK_LAST_CHECK_EN.
package conv_1d_pkg;

   localparam int OPAQUE_W = 8;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } bank_state_e;

   // LSB of element (channel k, column w) inside the flat lines vector.
   function automatic int elem_lsb(input int k, input int w, input int img_w, input int dw);
      return (k * img_w + w) * dw;
   endfunction

endpackage

// File: rtl/conv_line_bank.sv
// One line buffer bank: per-column write decode plus a line tag register.
module conv_line_bank
   import conv_1d_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_W      = 32,
   parameter int IMG_D      = 8,
   localparam int COL_AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              i_we,
   input  logic [COL_AW-1:0]                 i_col,
   input  logic [DATA_WIDTH*IMG_D-1:0]       i_data,
   input  logic                              i_tag_we,
   input  logic [OPAQUE_W-1:0]               i_tag,
   output logic [DATA_WIDTH*IMG_D*IMG_W-1:0] o_line,
   output logic [OPAQUE_W-1:0]               o_tag
);

   logic [DATA_WIDTH*IMG_D*IMG_W-1:0] r_line;
   logic [OPAQUE_W-1:0]               r_tag;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_line <= '0;
         r_tag  <= '0;
      end else begin
         // Scatter the beat's channels into their column slots of the flat vector.
         if (i_we) begin
            for (int w = 0; w < IMG_W; w++) begin
               if (i_col == COL_AW'(w)) begin
                  for (int k = 0; k < IMG_D; k++) begin
                     r_line[elem_lsb(k, w, IMG_W, DATA_WIDTH) +: DATA_WIDTH] <=
                        i_data[k*DATA_WIDTH +: DATA_WIDTH];
                  end
               end
            end
         end
         if (i_tag_we) r_tag <= i_tag;
      end
   end

   assign o_line = r_line;
   assign o_tag  = r_tag;

endmodule

// File: rtl/conv_line_packer_1d.sv
// Ping-pong packer: IMG_W beats -> one flat line for the 1-D conv stage.
// Build macro CONV_PACK_LAST_CHECK_EN adds in_last framing check and sticky err_out.
module conv_line_packer_1d
   import conv_1d_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_W      = 32,
   parameter int IMG_D      = 8,
   localparam int COL_AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [DATA_WIDTH*IMG_D-1:0]       in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [OPAQUE_W-1:0]               opaque_in,
   output logic [DATA_WIDTH*IMG_D*IMG_W-1:0] lines_out,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [OPAQUE_W-1:0]               opaque_out,
   output logic [3:0]                        dbg_bank_st
`ifdef CONV_PACK_LAST_CHECK_EN
   ,
   input  logic                              in_last,
   output logic                              err_out
`endif
);

   localparam int LW = DATA_WIDTH * IMG_D * IMG_W;

   logic [COL_AW-1:0]   r_wr_col;
   logic                r_wr_bank;
   logic                r_rd_bank;
   bank_state_e         r_bank_st   [2];
   bank_state_e         w_bank_nxt  [2];
   logic [LW-1:0]       w_line      [2];
   logic [OPAQUE_W-1:0] w_tag       [2];

   logic w_in_fire;
   logic w_out_fire;
   logic w_last_col;
   logic w_commit;
   logic w_discard;

   // Handshake: a beat transfers when in_valid & in_ready at a rising edge, a line when
   // out_valid & out_ready; both readies depend on registered state only.
   assign in_ready   = (r_bank_st[r_wr_bank] != FULL);
   assign out_valid  = (r_bank_st[r_rd_bank] == FULL);
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = out_valid & out_ready;
   assign w_last_col = (r_wr_col == COL_AW'(IMG_W - 1));
   assign w_commit   = w_in_fire & w_last_col;

`ifdef CONV_PACK_LAST_CHECK_EN
   logic r_err;
   assign w_discard = w_in_fire & in_last & ~w_last_col;
   assign err_out   = r_err;
`else
   assign w_discard = 1'b0;
`endif

   for (genvar b = 0; b < 2; b++) begin : g_bank
      logic w_we;
      assign w_we = w_in_fire & (r_wr_bank == 1'(b));
      conv_line_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .IMG_W      (IMG_W),
         .IMG_D      (IMG_D)
      ) u_bank (
         .clk      (clk),
         .reset    (reset),
         .i_we     (w_we),
         .i_col    (r_wr_col),
         .i_data   (in_data),
         .i_tag_we (w_we & (r_wr_col == '0)),
         .i_tag    (opaque_in),
         .o_line   (w_line[b]),
         .o_tag    (w_tag[b])
      );
   end

   // A FULL bank is never the write target and an unfilled bank never drains,
   // so the two updates below never collide on one bank.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         w_bank_nxt[b] = r_bank_st[b];
         if (w_out_fire && (r_rd_bank == 1'(b))) begin
            w_bank_nxt[b] = EMPTY;
         end
         if (w_in_fire && (r_wr_bank == 1'(b))) begin
            if (w_commit)       w_bank_nxt[b] = FULL;
            else if (w_discard) w_bank_nxt[b] = EMPTY;
            else                w_bank_nxt[b] = FILLING;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_col     <= '0;
         r_wr_bank    <= 1'b0;
         r_rd_bank    <= 1'b0;
         r_bank_st[0] <= EMPTY;
         r_bank_st[1] <= EMPTY;
      end else begin
         r_bank_st[0] <= w_bank_nxt[0];
         r_bank_st[1] <= w_bank_nxt[1];
         if (w_in_fire) begin
            if (w_commit) begin
               r_wr_col  <= '0;
               r_wr_bank <= ~r_wr_bank;
            end else if (w_discard) begin
               r_wr_col  <= '0;
            end else begin
               r_wr_col  <= r_wr_col + COL_AW'(1);
            end
         end
         if (w_out_fire) r_rd_bank <= ~r_rd_bank;
      end
   end

`ifdef CONV_PACK_LAST_CHECK_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if (w_discard || (w_commit && !in_last)) begin
         r_err <= 1'b1;
      end
   end
`endif

   assign lines_out   = w_line[r_rd_bank];
   assign opaque_out  = w_tag[r_rd_bank];
   assign dbg_bank_st = {r_bank_st[1], r_bank_st[0]};

endmodule

// File: tb/tb_conv_line_packer_1d.sv
// Randomised scoreboard bench for conv_line_packer_1d (DATA_WIDTH=8, IMG_W=4, IMG_D=2).
module tb_conv_line_packer_1d;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int D  = 2;
  localparam int BW = DW * D;
  localparam int LW = DW * D * W;
  localparam int EW = LW + 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    opaque_in = '0;
  logic [LW-1:0] lines_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    opaque_out;
  logic [3:0]    dbg_bank_st;
  logic          in_last = 1'b0;
`ifdef CONV_PACK_LAST_CHECK_EN
  logic          err_out;
`endif

  conv_line_packer_1d #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_D(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opaque_in   (opaque_in),
    .lines_out   (lines_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .opaque_out  (opaque_out),
    .dbg_bank_st (dbg_bank_st)
`ifdef CONV_PACK_LAST_CHECK_EN
    ,
    .in_last     (in_last),
    .err_out     (err_out)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Line = beats gathered in order; element (k,w) sits at (k*W+w)*DW.
  logic [BW-1:0] m_beats[$];
  logic [7:0]    m_tag;
  logic          m_err = 1'b0;

  function automatic logic [LW-1:0] build_line(input logic [BW-1:0] beats[$]);
    logic [LW-1:0] l;
    logic [BW-1:0] b;
    l = '0;
    for (int w = 0; w < W; w++) begin
      b = beats[w];
      for (int k = 0; k < D; k++) l[(k*W+w)*DW +: DW] = b[k*DW +: DW];
    end
    return l;
  endfunction

  task automatic model_beat(input logic [BW-1:0] d, input logic [7:0] t, input logic l);
    if (m_beats.size() == 0) m_tag = t;
    m_beats.push_back(d);
`ifdef CONV_PACK_LAST_CHECK_EN
    if (l && m_beats.size() < W) begin
      m_beats.delete();
      m_err = 1'b1;
      return;
    end
    if (m_beats.size() == W && !l) m_err = 1'b1;
`else
    if (l) m_err = m_err;
`endif
    if (m_beats.size() == W) begin
      exp_q.push_back({m_tag, build_line(m_beats)});
      m_beats.delete();
    end
  endtask

  // ---------------- driver ----------------
  task automatic send_beat(input logic [BW-1:0] d, input logic [7:0] t, input logic l);
    int cnt;
    cnt = 0;
    in_data = d; opaque_in = t; in_last = l; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      cnt++;
      if (cnt > 200) begin
        n_chk++;
        $display("FAIL beat_timeout: in_ready stuck at 0, beat %h dropped", d);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    model_beat(d, t, l);
  endtask

  task automatic send_line(input logic [7:0] t);
    for (int i = 0; i < W; i++)
      send_beat(BW'($urandom), t, i == W-1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_line: got %h with tag %h, none expected", lines_out, opaque_out);
      end else begin
        chk("line", {opaque_out, lines_out}, exp_q.pop_front());
      end
    end
  end

  int watch = 0, rdy_drops = 0, cyc = 0, ov_seen = 0;
  always @(negedge clk) if (watch == 1 && !in_ready) rdy_drops++;
  always @(negedge clk) if (watch == 2 && out_valid) ov_seen++;
  always @(posedge clk) if (watch == 1) cyc++;

  task automatic drain();
    int cnt;
    cnt = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && cnt < 500) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("drain_empty", EW'(exp_q.size()), EW'(0));
  endtask

  logic rand_rdy = 1'b0;

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  EW'(in_ready),    EW'(1));
    chk("rst_out_valid", EW'(out_valid),   EW'(0));
    chk("rst_lines_out", EW'(lines_out),   EW'(0));
    chk("rst_opaque",    EW'(opaque_out),  EW'(0));
    chk("rst_dbg",       EW'(dbg_bank_st), EW'(0));
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Single directed line with latency check
    out_ready = 1'b1;
    send_beat(16'h0100, 8'hA5, 1'b0);
    send_beat(16'h1110, 8'h00, 1'b0);
    send_beat(16'h2120, 8'h00, 1'b0);
    send_beat(16'h3130, 8'h00, 1'b1);
    @(negedge clk);
    chk("single_valid", EW'(out_valid),  EW'(1));
    chk("single_line",  EW'(lines_out),  EW'(64'h31211101_30201000));
    chk("single_tag",   EW'(opaque_out), EW'(8'hA5));
    @(posedge clk); #1;
    drain();

    // Backpressure: two lines buffered, ninth beat stalls
    out_ready = 1'b0;
    send_line(8'h11);
    send_line(8'h22);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("bp_in_ready", EW'(in_ready),    EW'(0));
    chk("bp_dbg_full", EW'(dbg_bank_st), EW'({2'd2, 2'd2}));
    chk("bp_tag_hold", EW'(opaque_out),  EW'(8'h11));
    in_valid = 1'b0;
    @(posedge clk); #1;
    fork
      begin repeat (5) @(posedge clk); #1; out_ready = 1'b1; end
      send_line(8'h33);
    join
    drain();

    // Full rate: eight lines back to back
    out_ready = 1'b1;
    rdy_drops = 0; cyc = 0; watch = 1;
    for (int n = 0; n < 8; n++) send_line(8'($urandom_range(0, 255)));
    watch = 0;
    chk("fr_no_stall", EW'(rdy_drops), EW'(0));
    chk("fr_cycles",   EW'(cyc),       EW'(8 * W));
    drain();

    // Random out_ready
    rand_rdy = 1'b1;
    fork
      while (rand_rdy) begin @(posedge clk); #1; out_ready = 1'($urandom_range(0, 1)); end
      begin
        for (int n = 0; n < 20; n++) send_line(8'($urandom_range(0, 255)));
        rand_rdy = 1'b0;
      end
    join
    drain();

    // Reset mid-line
    send_beat(BW'($urandom), 8'h5A, 1'b0);
    send_beat(BW'($urandom), 8'h5A, 1'b0);
    #2 reset = 1'b0;
    m_beats.delete();
    @(negedge clk); reset = 1'b1;
    ov_seen = 0; watch = 2;
    repeat (6) @(posedge clk);
    #1; watch = 0;
    chk("mid_rst_no_valid", EW'(ov_seen),     EW'(0));
    chk("mid_rst_dbg",      EW'(dbg_bank_st), EW'(0));
    send_line(8'h77);
    drain();

`ifdef CONV_PACK_LAST_CHECK_EN
    chk("err_clear", EW'(err_out), EW'(m_err));
    send_beat(BW'($urandom), 8'h99, 1'b0);
    send_beat(BW'($urandom), 8'h99, 1'b1);
    @(negedge clk);
    chk("err_set",      EW'(err_out),   EW'(m_err));
    chk("err_no_line",  EW'(out_valid), EW'(0));
    @(posedge clk); #1;
    send_line(8'h44);
    drain();
    chk("err_sticky", EW'(err_out), EW'(1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
